// File: rtl/e_mult_div_unit.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to enable MADD (md_op 7): {HI,LO} += signed(rs) * signed(rt).
module e_mult_div_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        md_cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_wr;

    logic          is_long;
    logic          accept;
    logic [CW-1:0] lat_sel;

    logic signed [63:0] rs_sx;
    logic signed [63:0] rt_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_ovf;
    logic [31:0]        divisor;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic [63:0]        res;
    logic               res_wr;

    always_comb begin
        is_long = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                  (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_long = is_long || (md_op == OP_MADD);
`endif
    end

    assign accept    = start & ~md_cancel & ~busy;
    assign stall_req = busy | (start & ~md_cancel & is_long);
    assign lat_sel   = ((md_op == OP_DIV) || (md_op == OP_DIVU)) ? CW'(DIV_LAT) : CW'(MUL_LAT);

    assign rs_sx  = {{32{rs_val[31]}}, rs_val};
    assign rt_sx  = {{32{rt_val[31]}}, rt_val};
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // The divider never sees a zero divisor or the one overflowing signed pair;
    // both are resolved explicitly below.
    assign div_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    assign divisor = ((rt_val == 32'd0) || div_ovf) ? 32'd1 : rt_val;
    assign quo_s   = div_ovf ? 32'h8000_0000 : 32'($signed(rs_val) / $signed(divisor));
    assign rem_s   = div_ovf ? 32'd0         : 32'($signed(rs_val) % $signed(divisor));
    assign quo_u   = rs_val / divisor;
    assign rem_u   = rs_val % divisor;

    always_comb begin
        res    = 64'd0;
        res_wr = 1'b0;
        case (md_op)
            OP_MULT: begin
                res    = prod_s;
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res    = prod_u;
                res_wr = 1'b1;
            end
            OP_DIV: begin
                res    = {rem_s, quo_s};
                res_wr = (rt_val != 32'd0);
            end
            OP_DIVU: begin
                res    = {rem_u, quo_u};
                res_wr = (rt_val != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res    = {hi, lo} + prod_s;
                res_wr = 1'b1;
            end
`endif
            default: begin
                res    = 64'd0;
                res_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                if (pend_wr) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end else if (accept) begin
            if (md_op == OP_MTHI) begin
                hi <= rs_val;
            end else if (md_op == OP_MTLO) begin
                lo <= rs_val;
            end else if (is_long) begin
                busy    <= 1'b1;
                cnt     <= lat_sel;
                pend_hi <= res[63:32];
                pend_lo <= res[31:0];
                pend_wr <= res_wr;
            end
        end
    end

endmodule

// File: doc/e_mult_div_unit.md
# e_mult_div_unit

Execute-stage multiply/divide unit with HI/LO registers. It consumes the operand and instruction fields latched by the D→E pipeline register. It runs MULT/MULTU for 5 cycles and DIV/DIVU for 10 cycles, and handles MTHI/MTLO writes in one cycle. It exposes `busy` and the architectural HI/LO values to the hazard unit and the E-stage result mux. A cancel input suppresses an operation whose E-stage instruction is being flushed by an interrupt or exception.

## Interface
- `MUL_LAT`, default 5: cycles `busy` stays high for MULT/MULTU (and MADD when enabled).
- `DIV_LAT`, default 10: cycles `busy` stays high for DIV/DIVU.
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: synchronous, active-low; sampled on `clk` rising edge.
- `start` input, 1: an MD instruction is in E this cycle.
- `md_op` input, 3: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD (macro-dependent).
- `md_cancel` input, 1: the E-stage instruction is being flushed by an interrupt or exception; gates `start`.
- `rs_val` input, 32: forwarded RS operand in E.
- `rt_val` input, 32: forwarded RT operand in E.
- `busy` output, 1: a multi-cycle operation is in progress.
- `stall_req` output, 1: combinational; `busy | (start & !md_cancel & md_op∈{1,2,3,4,7})`.
- `hi` output, 32: architectural HI register.
- `lo` output, 32: architectural LO register.

## Operation
- Reset (`reset==0` at an edge) sets `hi=0`, `lo=0`, `busy=0`, the cycle counter to 0 and the pending result to 0. Reset takes priority over everything, including an operation mid-flight, which is discarded.
- An accepted start is `start & !md_cancel & !busy`.
  - A start while `busy` is ignored; the hazard unit guarantees this does not occur.
  - With `md_cancel` high, nothing happens: no HI/LO write and no `busy`.
- MTHI/MTLO: on the accepted edge, `hi<=rs_val` or `lo<=rs_val`. `busy` stays 0.
- Long ops (MULT/MULTU/DIV/DIVU/MADD): the result is computed from the operands at the accept edge into the pending {HI,LO}. The counter loads `MUL_LAT` or `DIV_LAT` and `busy<=1`.
- While busy, the counter decrements each cycle. On the edge where the counter goes 1→0:
  - `hi`/`lo` take the pending value;
  - `busy<=0`.
- `md_cancel` during `busy` has no effect; the issuing instruction has already left E.
- Arithmetic:
  - MULT: signed 32×32→64, {HI,LO}.
  - MULTU: unsigned 32×32→64.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0 (DIV/DIVU): the op still takes `DIV_LAT` cycles; HI/LO are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `md_op` 0 or any undefined code: no effect.
- `hi`/`lo` are register outputs. MFHI/MFLO read them through the E-stage mux, and the hazard unit stalls them via `stall_req`.

## Timing
- Accept edge at the end of cycle T: `busy` is high in cycles T+1 .. T+LAT.
  - New HI/LO are visible from cycle T+LAT+1.
  - `busy` is low in cycle T+LAT+1.
- `stall_req` is high in cycle T (combinational from `start`) and through T+LAT.
- MTHI/MTLO: new value visible in cycle T+1. No stall.
- A new start is allowed in the first cycle with `busy==0`, back-to-back with completion.
- `reset` low in any cycle: all outputs hold their reset values from the next cycle.

## Configuration
- `MDU_MADD_EN` defined:
  - `md_op`=7 (MADD) computes `{HI,LO} + signed(rs_val)*signed(rt_val)`, mod 2^64.
  - It uses the HI/LO values at the accept edge and `MUL_LAT` latency.
- Not defined: `md_op`=7 is treated as NONE. `stall_req` excludes code 7, and no accumulator adder is synthesized.

## Test plan
- After reset release, MULT with rs=0xFFFFFFFF, rt=0x00000002 → `busy` high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. An immediately following DIV with rs=0xFFFFFFF9 (-7), rt=2 → `busy` high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Start DIVU rs=123, rt=0 → `busy` high 10 cycles, hi/lo unchanged. MTLO rs=0x12345678 → lo=0x12345678 next cycle, `busy` stays 0.
- MULT with `start` and `md_cancel` both high → `busy` stays 0, `stall_req` stays 0, hi/lo unchanged. Set `md_cancel` high in cycle T+2 of a running MULT → the MULT still completes normally.
- Drive `reset` low in cycle T+3 of a DIV → `busy`=0, hi=lo=0 from the next cycle, with no later HI/LO write.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, then MADD rs=1, rt=1 → hi=1, lo=0 after 5 cycles. Without the macro, the same op leaves hi/lo unchanged and `busy` stays 0.
